// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//   UART receiver: 8 data bits LSB-first, one stop bit, optional even parity.
//   The serial line is double-flopped before any decision is made. A byte that
//   passes its stop (and parity) check is presented on data_o with valid_o and
//   is held until the consumer takes it with ready_i.
//
//   Build option:
//     UART_RX_PARITY_EN  defined   -> 8E1 frames, parity_err_o active
//                        undefined -> 8N1 frames, parity_err_o held at 0
//
//   Parameter:
//     CLKS_PER_BIT  clk cycles per serial bit (even, 4..4096)
//
//   Ports:
//     clk           clock, all state changes on posedge
//     rst           synchronous active-low reset
//     rx_i          asynchronous serial input, idles high
//     ready_i       consumer accepts data_o this cycle
//     data_o        received byte, stable while valid_o is high
//     valid_o       data_o holds an unconsumed byte
//     busy_o        receiver is inside a frame (FSM not in IDLE)
//     frame_err_o   one-cycle pulse: stop bit sampled low
//     overrun_o     one-cycle pulse: a good byte was dropped (valid_o held)
//     parity_err_o  one-cycle pulse: parity mismatch
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            rx_meta;
  logic            rx_s;
  logic [BW-1:0]   baud_cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shift_reg;

  logic            baud_last;
  logic            baud_half;
  logic            data_sample;
  logic            stop_sample;
  logic            frame_bad;
  logic            par_bad;
  logic            deliver;

`ifdef UART_RX_PARITY_EN
  logic            par_bit;
  logic            par_sample;
`endif

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign baud_half = (baud_cnt == BAUD_HALF);

  // ---------------------------------------------------------------------------
  // Input synchronizer; resets to the idle (high) line level so a reset never
  // looks like a start bit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        // Mid start bit: still low means a real frame, high means a glitch.
        if (baud_half) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        // Leave on the sample of bit 7, i.e. the sample that makes bit_cnt 8.
        if (baud_last && (bit_cnt == 4'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_last) state_next = STOP;
      end
`endif
      STOP: begin
        if (baud_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o      = (state != IDLE);
    data_sample = (state == DATA) && baud_last;
    stop_sample = (state == STOP) && baud_last;
    frame_bad   = stop_sample && !rx_s;
`ifdef UART_RX_PARITY_EN
    par_sample  = (state == PARITY) && baud_last;
    par_bad     = stop_sample && (par_bit != (^shift_reg));
`else
    par_bad     = 1'b0;
`endif
    deliver     = stop_sample && rx_s && !par_bad;
  end

  // ---------------------------------------------------------------------------
  // Baud / bit counters and shift register. Counters clear on every state
  // change so each state times itself from zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (state_next != state) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if ((state == IDLE) || baud_last) begin
          baud_cnt <= '0;
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
        if (data_sample) begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
      // LSB arrives first, so shift right with the new bit entering at bit 7.
      if (data_sample) begin
        shift_reg <= {rx_s, shift_reg[7:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      par_bit <= 1'b0;
    end else if (par_sample) begin
      par_bit <= rx_s;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Output holding register and status pulses. A new byte is dropped only when
  // the old one is still pending and not being taken in this same cycle; if
  // it is being taken, the new byte replaces it and valid_o stays high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      frame_err_o  <= frame_bad;
      parity_err_o <= par_bad;
      overrun_o    <= deliver && valid_o && !ready_i;

      if (deliver) begin
        if (!valid_o || ready_i) begin
          data_o  <= shift_reg;
          valid_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;

  int unsigned total;
  int unsigned bad;

  // Scoreboard of bytes that must be handed over, in order.
  logic [7:0] exp_q[$];

  // Event counters maintained by the monitor.
  int unsigned valid_cycles;
  int unsigned fe_cnt;
  int unsigned ov_cnt;
  int unsigned pe_cnt;
  int unsigned pop_cnt;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx_i),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .busy_o       (busy_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (valid_o)      valid_cycles++;
      if (frame_err_o)  fe_cnt++;
      if (overrun_o)    ov_cnt++;
      if (parity_err_o) pe_cnt++;
      if (valid_o && ready_i) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, data_o}, 32'hFFFF_FFFF);
        end else begin
          check("data", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Frame with correct parity (when compiled in) and a chosen stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_bit);
    rx_i = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par_frame(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  int unsigned v0, f0, o0, p0, q0;

  task automatic snap();
    v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt; q0 = pop_cnt;
  endtask

  initial begin
    total = 0; bad = 0;
    valid_cycles = 0; fe_cnt = 0; ov_cnt = 0; pe_cnt = 0; pop_cnt = 0;
    rx_i = 1'b1;
    ready_i = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_data",   {24'd0, data_o}, 32'h00);
    check("rst_valid",  {31'd0, valid_o}, 32'd0);
    check("rst_busy",   {31'd0, busy_o}, 32'd0);
    check("rst_ferr",   {31'd0, frame_err_o}, 32'd0);
    check("rst_ovr",    {31'd0, overrun_o}, 32'd0);
    check("rst_perr",   {31'd0, parity_err_o}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5, ready high: one handshake cycle, no error pulses
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check("a5_pops",      pop_cnt - q0, 32'd1);
    check("a5_valid_cyc", valid_cycles - v0, 32'd1);
    check("a5_ferr",      fe_cnt - f0, 32'd0);
    check("a5_ovr",       ov_cnt - o0, 32'd0);
    check("a5_perr",      pe_cnt - p0, 32'd0);
    check("a5_busy",      {31'd0, busy_o}, 32'd0);

    // 6-cycle low glitch: rejected at the mid start-bit check
    snap();
    rx_i = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy_in", {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy_out", {31'd0, busy_o}, 32'd0);
    check("glitch_valid",    valid_cycles - v0, 32'd0);
    check("glitch_errs",     (fe_cnt - f0) + (ov_cnt - o0) + (pe_cnt - p0), 32'd0);

    // 0x3C with stop bit low: frame error, nothing delivered
    snap();
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    check("ferr_pulse", fe_cnt - f0, 32'd1);
    check("ferr_valid", valid_cycles - v0, 32'd0);
    check("ferr_busy",  {31'd0, busy_o}, 32'd0);

    // 0x11 then 0x22 back-to-back with ready low: 0x22 dropped, overrun
    snap();
    ready_i = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_data",  {24'd0, data_o}, 32'h11);
    check("ovr_valid", {31'd0, valid_o}, 32'd1);
    check("ovr_pulse", ov_cnt - o0, 32'd1);
    check("ovr_ferr",  fe_cnt - f0, 32'd0);
    ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_pops",   pop_cnt - q0, 32'd1);
    check("ovr_drain",  {31'd0, valid_o}, 32'd0);

    // Reset pulse during bit 4 of 0xFF, then 0x5A
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (8) @(negedge clk);
    check("mid_busy_pre", {31'd0, busy_o}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_busy",  {31'd0, busy_o}, 32'd0);
    check("mid_rst_data",  {24'd0, data_o}, 32'h00);
    check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    rx_i = 1'b1;
    repeat (60) @(negedge clk);
    snap();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check("after_rst_pops",  pop_cnt - q0, 32'd1);
    check("after_rst_valid", valid_cycles - v0, 32'd1);
    check("after_rst_errs",  (fe_cnt - f0) + (ov_cnt - o0) + (pe_cnt - p0), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 0x07 (three ones) needs parity 1; 0 is a mismatch
    snap();
    send_par_frame(8'h07, 1'b0);
    repeat (20) @(negedge clk);
    check("par_bad_pulse", pe_cnt - p0, 32'd1);
    check("par_bad_valid", valid_cycles - v0, 32'd0);
    snap();
    exp_q.push_back(8'h07);
    send_par_frame(8'h07, 1'b1);
    repeat (20) @(negedge clk);
    check("par_ok_pops",  pop_cnt - q0, 32'd1);
    check("par_ok_perr",  pe_cnt - p0, 32'd0);
`else
    check("noparity_perr_total", pe_cnt, 32'd0);
`endif

    check("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
